// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with big-endian load-lane extraction and HI/LO registers.
// HI/LO outputs bypass the write that is still sitting in the W stage.
module mem_wb_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        StallW,
   input  logic        FlushW,
   input  logic        RegWriteM,
   input  logic        MemtoRegM,
   input  logic [2:0]  MemReadTypeM,
   input  logic [31:0] ALUoutM,
   input  logic [31:0] RAMdataM,
   input  logic [5:0]  WriteRegisterM,
   input  logic [1:0]  HiLoWriteM,
   input  logic [63:0] HiLoDataM,
   output logic        RegWriteW,
   output logic [5:0]  WriteRegisterW,
   output logic [31:0] WriteDataW,
   output logic [31:0] HIout,
   output logic [31:0] LOout
);

   logic        reg_write_w;
   logic        memto_reg_w;
   logic [2:0]  read_type_w;
   logic [31:0] alu_out_w;
   logic [31:0] ram_data_w;
   logic [5:0]  write_reg_w;
   logic [1:0]  hilo_write_w;
   logic [63:0] hilo_data_w;

   logic [31:0] hi_reg;
   logic [31:0] lo_reg;

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic        sign_ext;
   logic [31:0] load_value;

   // W-stage register set: flush beats stall, stall beats capture.
   always_ff @(posedge clk) begin
      if (!rst) begin
         reg_write_w  <= 1'b0;
         memto_reg_w  <= 1'b0;
         read_type_w  <= 3'b000;
         alu_out_w    <= 32'h0;
         ram_data_w   <= 32'h0;
         write_reg_w  <= 6'h0;
         hilo_write_w <= 2'b00;
         hilo_data_w  <= 64'h0;
      end else if (FlushW) begin
         reg_write_w  <= 1'b0;
         memto_reg_w  <= 1'b0;
         read_type_w  <= 3'b000;
         alu_out_w    <= 32'h0;
         ram_data_w   <= 32'h0;
         write_reg_w  <= 6'h0;
         hilo_write_w <= 2'b00;
         hilo_data_w  <= 64'h0;
      end else if (!StallW) begin
         reg_write_w  <= RegWriteM;
         memto_reg_w  <= MemtoRegM;
         read_type_w  <= MemReadTypeM;
         alu_out_w    <= ALUoutM;
         ram_data_w   <= RAMdataM;
         write_reg_w  <= WriteRegisterM;
         hilo_write_w <= HiLoWriteM;
         hilo_data_w  <= HiLoDataM;
      end
   end

   // The instruction leaving W retires its HI/LO write even if the stage is flushed or stalled.
   always_ff @(posedge clk) begin
      if (!rst) begin
         hi_reg <= 32'h0;
         lo_reg <= 32'h0;
      end else begin
         if (hilo_write_w[1]) begin
            hi_reg <= hilo_data_w[63:32];
         end
         if (hilo_write_w[0]) begin
            lo_reg <= hilo_data_w[31:0];
         end
      end
   end

   // Byte offset 0 is the most significant lane of the memory word.
   always_comb begin
      byte_lane = 8'h0;
      case (alu_out_w[1:0])
         2'b00:   byte_lane = ram_data_w[31:24];
         2'b01:   byte_lane = ram_data_w[23:16];
         2'b10:   byte_lane = ram_data_w[15:8];
         default: byte_lane = ram_data_w[7:0];
      endcase
   end

   assign half_lane = alu_out_w[1] ? ram_data_w[15:0] : ram_data_w[31:16];
   assign sign_ext  = read_type_w[2];

   // Misaligned halfwords and the unused type encoding both load zero.
   always_comb begin
      load_value = 32'h0;
      case (read_type_w[1:0])
         2'b00:   load_value = {{24{sign_ext & byte_lane[7]}}, byte_lane};
         2'b01:   load_value = alu_out_w[0] ? 32'h0 : {{16{sign_ext & half_lane[15]}}, half_lane};
         2'b10:   load_value = ram_data_w;
         default: load_value = 32'h0;
      endcase
   end

   assign RegWriteW      = reg_write_w & (write_reg_w != 6'd0);
   assign WriteRegisterW = write_reg_w;
   assign WriteDataW     = memto_reg_w ? load_value : alu_out_w;

   assign HIout = hilo_write_w[1] ? hilo_data_w[63:32] : hi_reg;
   assign LOout = hilo_write_w[0] ? hilo_data_w[31:0]  : lo_reg;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage: load lanes, stall/flush, HI/LO bypass, $0 and reset.
module tb_mem_wb_stage;

   logic        clk;
   logic        rst;
   logic        StallW;
   logic        FlushW;
   logic        RegWriteM;
   logic        MemtoRegM;
   logic [2:0]  MemReadTypeM;
   logic [31:0] ALUoutM;
   logic [31:0] RAMdataM;
   logic [5:0]  WriteRegisterM;
   logic [1:0]  HiLoWriteM;
   logic [63:0] HiLoDataM;
   logic        RegWriteW;
   logic [5:0]  WriteRegisterW;
   logic [31:0] WriteDataW;
   logic [31:0] HIout;
   logic [31:0] LOout;

   int checkCount = 0;
   int passCount  = 0;

   mem_wb_stage dut (
      .clk            (clk),
      .rst            (rst),
      .StallW         (StallW),
      .FlushW         (FlushW),
      .RegWriteM      (RegWriteM),
      .MemtoRegM      (MemtoRegM),
      .MemReadTypeM   (MemReadTypeM),
      .ALUoutM        (ALUoutM),
      .RAMdataM       (RAMdataM),
      .WriteRegisterM (WriteRegisterM),
      .HiLoWriteM     (HiLoWriteM),
      .HiLoDataM      (HiLoDataM),
      .RegWriteW      (RegWriteW),
      .WriteRegisterW (WriteRegisterW),
      .WriteDataW     (WriteDataW),
      .HIout          (HIout),
      .LOout          (LOout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Drive M-side inputs and control, then advance one rising edge and settle.
   task automatic applyStimulus(input logic stall, input logic flush, input logic rw, input logic m2r,
                                input logic [2:0] rtype, input logic [31:0] alu, input logic [31:0] ram,
                                input logic [5:0] wreg, input logic [1:0] hlw, input logic [63:0] hld);
      StallW         = stall;
      FlushW         = flush;
      RegWriteM      = rw;
      MemtoRegM      = m2r;
      MemReadTypeM   = rtype;
      ALUoutM        = alu;
      RAMdataM       = ram;
      WriteRegisterM = wreg;
      HiLoWriteM     = hlw;
      HiLoDataM      = hld;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 3'b010, 32'h1234_5678, 32'hFFFF_FFFF, 6'd9, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 3'b010, 32'h1234_5678, 32'hFFFF_FFFF, 6'd9, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF);
      checkOutput("reset RegWriteW",      {31'h0, RegWriteW},      32'h0);
      checkOutput("reset WriteRegisterW", {26'h0, WriteRegisterW}, 32'h0);
      checkOutput("reset WriteDataW",     WriteDataW,              32'h0);
      checkOutput("reset HIout",          HIout,                   32'h0);
      checkOutput("reset LOout",          LOout,                   32'h0);

      rst = 1'b1;
      // Signed byte at offset 1.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 3'b100, 32'h0000_0101, 32'h1285_3456, 6'd5, 2'b00, 64'h0);
      checkOutput("sbyte data",  WriteDataW,              32'hFFFF_FF85);
      checkOutput("sbyte rw",    {31'h0, RegWriteW},      32'h1);
      checkOutput("sbyte reg",   {26'h0, WriteRegisterW}, 32'h5);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 32'h0000_0003, 32'h1285_3456, 6'd5, 2'b00, 64'h0);
      checkOutput("ubyte lane3", WriteDataW, 32'h0000_0056);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 3'b100, 32'h0000_0000, 32'h1285_3456, 6'd5, 2'b00, 64'h0);
      checkOutput("sbyte lane0", WriteDataW, 32'h0000_0012);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 32'h0000_0102, 32'h1285_3456, 6'd5, 2'b00, 64'h0);
      checkOutput("ubyte lane2", WriteDataW, 32'h0000_0034);

      // Halfword lanes and misalignment.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 3'b001, 32'h0000_0002, 32'h8001_7FFE, 6'd6, 2'b00, 64'h0);
      checkOutput("uhalf lo",    WriteDataW, 32'h0000_7FFE);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 3'b101, 32'h0000_0000, 32'h8001_7FFE, 6'd6, 2'b00, 64'h0);
      checkOutput("shalf hi",    WriteDataW, 32'hFFFF_8001);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 3'b101, 32'h0000_0001, 32'h8001_7FFE, 6'd6, 2'b00, 64'h0);
      checkOutput("half mis01",  WriteDataW, 32'h0000_0000);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 3'b001, 32'h0000_0000, 32'h8001_7FFE, 6'd6, 2'b00, 64'h0);
      checkOutput("uhalf hi",    WriteDataW, 32'h0000_8001);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 3'b001, 32'h0000_0003, 32'h8001_7FFE, 6'd6, 2'b00, 64'h0);
      checkOutput("half mis11",  WriteDataW, 32'h0000_0000);

      // Word loads and the reserved encoding.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 3'b010, 32'h0000_0003, 32'h8001_7FFE, 6'd6, 2'b00, 64'h0);
      checkOutput("word",        WriteDataW, 32'h8001_7FFE);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 3'b011, 32'h0000_0000, 32'h8001_7FFE, 6'd6, 2'b00, 64'h0);
      checkOutput("type11",      WriteDataW, 32'h0000_0000);

      // Stall holds the ALU result, then flush under stall clears it.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 32'hDEAD_BEEF, 32'h8001_7FFE, 6'd7, 2'b00, 64'h0);
      checkOutput("alu path",    WriteDataW, 32'hDEAD_BEEF);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h1000_0000 + i, 32'hCAFE_F00D, 6'd8 + 6'(i), 2'b00, 64'h0);
         checkOutput("stall data", WriteDataW,              32'hDEAD_BEEF);
         checkOutput("stall reg",  {26'h0, WriteRegisterW}, 32'h7);
      end
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 32'h1234_0000, 32'h0, 6'd9, 2'b00, 64'h0);
      checkOutput("flush rw",    {31'h0, RegWriteW},      32'h0);
      checkOutput("flush data",  WriteDataW,              32'h0);
      checkOutput("flush reg",   {26'h0, WriteRegisterW}, 32'h0);

      // HI/LO bypass and partial writes.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 6'd0, 2'b11, 64'h1111_2222_3333_4444);
      checkOutput("hilo bypass hi", HIout, 32'h1111_2222);
      checkOutput("hilo bypass lo", LOout, 32'h3333_4444);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 6'd0, 2'b01, 64'hAAAA_AAAA_5555_5555);
      checkOutput("lo-only hi",     HIout, 32'h1111_2222);
      checkOutput("lo-only lo",     LOout, 32'h5555_5555);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 6'd0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF);
      checkOutput("hilo reg hi",    HIout, 32'h1111_2222);
      checkOutput("hilo reg lo",    LOout, 32'h5555_5555);

      // A HI write leaving W still retires when that edge flushes.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 6'd0, 2'b10, 64'h7777_8888_9999_0000);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 6'd0, 2'b11, 64'h0);
      checkOutput("flush retire hi", HIout, 32'h7777_8888);
      checkOutput("flush retire lo", LOout, 32'h5555_5555);

      // Register $0 is never written.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 32'h0000_00AB, 32'h0, 6'd0, 2'b00, 64'h0);
      checkOutput("zero reg rw",   {31'h0, RegWriteW}, 32'h0);
      checkOutput("zero reg data", WriteDataW,         32'h0000_00AB);

      // Reset during a stall discards the held HI write.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 32'h0000_0042, 32'h0, 6'd3, 2'b10, 64'h9999_9999_0000_0000);
      checkOutput("pre-reset HIout", HIout, 32'h9999_9999);
      rst = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'h0000_0042, 32'h0, 6'd3, 2'b10, 64'h9999_9999_0000_0000);
      checkOutput("mid-stall rst HI",   HIout,                   32'h0);
      checkOutput("mid-stall rst LO",   LOout,                   32'h0);
      checkOutput("mid-stall rst rw",   {31'h0, RegWriteW},      32'h0);
      checkOutput("mid-stall rst reg",  {26'h0, WriteRegisterW}, 32'h0);
      checkOutput("mid-stall rst data", WriteDataW,              32'h0);
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 6'd0, 2'b00, 64'h0);
      checkOutput("post-rst HI", HIout, 32'h0);
      checkOutput("post-rst LO", LOout, 32'h0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
